// File: rtl/timed_gpo_dispatcher_pkg.sv
// Shared types for the timed GPO dispatcher: FSM states, the queued entry
// layout and the minimum spacing between consecutive fires.
package gpo_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ARMED = 2'd2
   } gpo_state_t;

   // ARMED -> IDLE -> LOAD -> ARMED: the earliest the next entry can fire
   localparam int unsigned MIN_SPACING = 3;

   localparam int unsigned DEF_TIME_WIDTH = 64;
   localparam int unsigned DEF_DATA_WIDTH = 128;

   typedef struct packed {
      logic [DEF_TIME_WIDTH-1:0] stamp;
      logic [DEF_DATA_WIDTH-1:0] payload;
   } gpo_entry_t;

endpackage

// File: rtl/timed_gpo_dispatcher_sync_fifo_reg.sv
// Single-clock FIFO with a registered read port (data valid the cycle after
// rd_en), occupancy count and a synchronous flush.
module sync_fifo_reg #(
   parameter int unsigned WIDTH = 192,
   parameter int unsigned DEPTH = 16
) (
   input  logic                    CLK100MHZ,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    rd_en,
   output logic [WIDTH-1:0]        rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

   logic [WIDTH-1:0]     mem_r [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_r;
   logic [PTR_WIDTH-1:0] rd_ptr_r;
   logic [CNT_WIDTH-1:0] count_r;
   logic [WIDTH-1:0]     rd_data_r;
   logic                 full_s;
   logic                 empty_s;
   logic                 push_s;
   logic                 pop_s;

   // Occupancy flags and qualified push/pop strobes
   always_comb begin
      full_s  = (count_r == CNT_WIDTH'(DEPTH));
      empty_s = (count_r == CNT_WIDTH'(0));
      push_s  = wr_en && !full_s && !flush;
      pop_s   = rd_en && !empty_s && !flush;
   end

   // Storage array; left unreset so it maps onto plain RAM/flops
   always_ff @(posedge CLK100MHZ) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, count and registered read data
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         rd_data_r <= '0;
      end else if (flush) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
         end
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_WIDTH'(1);
            rd_data_r <= mem_r[rd_ptr_r];
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_WIDTH'(1);
            2'b01:   count_r <= count_r - CNT_WIDTH'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_data = rd_data_r;
   assign full    = full_s;
   assign empty   = empty_s;
   assign count   = count_r;

endmodule

// File: rtl/timed_gpo_dispatcher.sv
// Timed-update producer for the GPO core: queues timestamped words and fires
// each one with a single-cycle counter_matched strobe once its time is reached.
module timed_gpo_dispatcher
   import gpo_dispatch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TIME_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 128
) (
   input  logic                          CLK100MHZ,
   input  logic                          reset,
   input  logic [TIME_WIDTH-1:0]         counter,
   input  logic                          wr_en,
   input  logic [TIME_WIDTH-1:0]         wr_time,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          flush,
   input  logic                          clear_errors,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [DATA_WIDTH-1:0]         gpo_data,
   output logic                          counter_matched,
   output logic                          late_error,
   output logic [DATA_WIDTH-1:0]         late_data,
   output logic                          overflow_error
);

   localparam int unsigned ENTRY_WIDTH = TIME_WIDTH + DATA_WIDTH;

   gpo_state_t              state_r;
   gpo_state_t              state_next_s;
   logic                    pop_s;
   logic                    head_load_s;
   logic                    fire_s;
   logic                    late_s;
   logic                    overflow_set_s;
   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic [ENTRY_WIDTH-1:0]  fifo_rd_s;
   logic [TIME_WIDTH-1:0]   head_time_r;
   logic [DATA_WIDTH-1:0]   head_data_r;
   logic                    counter_matched_r;
   logic [DATA_WIDTH-1:0]   gpo_data_r;
   logic                    late_error_r;
   logic [DATA_WIDTH-1:0]   late_data_r;
   logic                    overflow_error_r;

   sync_fifo_reg #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .flush     (flush),
      .wr_en     (wr_en),
      .wr_data   ({wr_time, wr_data}),
      .rd_en     (pop_s),
      .rd_data   (fifo_rd_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count)
   );

   // Next-state logic; flush overrides everything, including a pending match
   always_comb begin
      state_next_s = state_r;
      pop_s        = 1'b0;
      head_load_s  = 1'b0;
      fire_s       = 1'b0;
      if (flush) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (!fifo_empty_s) begin
                  pop_s        = 1'b1;
                  state_next_s = LOAD;
               end else begin
                  state_next_s = IDLE;
               end
            end
            LOAD: begin
               head_load_s  = 1'b1;
               state_next_s = ARMED;
            end
            ARMED: begin
               if (counter >= head_time_r) begin
                  fire_s       = 1'b1;
                  state_next_s = IDLE;
               end else begin
                  state_next_s = ARMED;
               end
            end
            default: begin
               state_next_s = IDLE;
            end
         endcase
      end
   end

   // Error qualifiers; a write coinciding with flush is ignored entirely
   always_comb begin
      late_s         = fire_s && (counter != head_time_r);
      overflow_set_s = wr_en && !flush && fifo_full_s;
   end

   // State, head entry and registered outputs; error sets win over clears
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state_r           <= IDLE;
         head_time_r       <= '0;
         head_data_r       <= '0;
         counter_matched_r <= 1'b0;
         gpo_data_r        <= '0;
         late_error_r      <= 1'b0;
         late_data_r       <= '0;
         overflow_error_r  <= 1'b0;
      end else begin
         state_r           <= state_next_s;
         counter_matched_r <= fire_s;
         if (head_load_s) begin
            head_time_r <= fifo_rd_s[ENTRY_WIDTH-1:DATA_WIDTH];
            head_data_r <= fifo_rd_s[DATA_WIDTH-1:0];
         end
         if (fire_s) begin
            gpo_data_r <= head_data_r;
         end
         if (late_s) begin
            late_error_r <= 1'b1;
            late_data_r  <= head_data_r;
         end else if (clear_errors) begin
            late_error_r <= 1'b0;
         end
         if (overflow_set_s) begin
            overflow_error_r <= 1'b1;
         end else if (clear_errors) begin
            overflow_error_r <= 1'b0;
         end
      end
   end

   assign full            = fifo_full_s;
   assign empty           = fifo_empty_s && (state_r == IDLE);
   assign gpo_data        = gpo_data_r;
   assign counter_matched = counter_matched_r;
   assign late_error      = late_error_r;
   assign late_data       = late_data_r;
   assign overflow_error  = overflow_error_r;

endmodule

// File: tb/tb_timed_gpo_dispatcher.sv
// Directed self-checking bench for timed_gpo_dispatcher.
module tb_timed_gpo_dispatcher;
   import gpo_dispatch_pkg::*;

   logic          CLK100MHZ = 1'b0;
   logic          reset = 1'b1;
   logic [63:0]   counter;
   logic          cnt_load = 1'b1;
   logic [63:0]   cnt_load_val = 64'd0;
   logic          wr_en = 1'b0;
   logic [63:0]   wr_time = 64'd0;
   logic [127:0]  wr_data = 128'd0;
   logic          flush = 1'b0;
   logic          clear_errors = 1'b0;
   logic          full;
   logic          empty;
   logic [4:0]    fifo_count;
   logic [127:0]  gpo_data;
   logic          counter_matched;
   logic          late_error;
   logic [127:0]  late_data;
   logic          overflow_error;

   int checks = 0;
   int failures = 0;

   timed_gpo_dispatcher #(
      .FIFO_DEPTH (16),
      .TIME_WIDTH (64),
      .DATA_WIDTH (128)
   ) dut (
      .CLK100MHZ       (CLK100MHZ),
      .reset           (reset),
      .counter         (counter),
      .wr_en           (wr_en),
      .wr_time         (wr_time),
      .wr_data         (wr_data),
      .flush           (flush),
      .clear_errors    (clear_errors),
      .full            (full),
      .empty           (empty),
      .fifo_count      (fifo_count),
      .gpo_data        (gpo_data),
      .counter_matched (counter_matched),
      .late_error      (late_error),
      .late_data       (late_data),
      .overflow_error  (overflow_error)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   // Free-running global counter with a load hook for the tests
   always @(posedge CLK100MHZ) begin
      if (cnt_load) counter <= cnt_load_val;
      else          counter <= counter + 64'd1;
   end

   task automatic set_counter(input logic [63:0] v);
      cnt_load_val = v;
      cnt_load = 1'b1;
      @(negedge CLK100MHZ);
      cnt_load = 1'b0;
   endtask

   task automatic write_entry(input logic [63:0] t, input logic [127:0] d);
      wr_en = 1'b1;
      wr_time = t;
      wr_data = d;
      @(negedge CLK100MHZ);
      wr_en = 1'b0;
   endtask

   task automatic pulse_clear;
      clear_errors = 1'b1;
      @(negedge CLK100MHZ);
      clear_errors = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge CLK100MHZ);
      reset = 1'b0;
      cnt_load = 1'b0;
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      checks++;
      if (full !== 1'b0 || fifo_count !== 5'd0) begin
         failures++; $display("FAIL reset_fifo full=%0b count=%0d exp 0/0", full, fifo_count);
      end
      checks++;
      if (counter_matched !== 1'b0 || gpo_data !== 128'd0) begin
         failures++; $display("FAIL reset_out matched=%0b gpo=%0h exp 0/0", counter_matched, gpo_data);
      end
      checks++;
      if (late_error !== 1'b0 || late_data !== 128'd0 || overflow_error !== 1'b0) begin
         failures++; $display("FAIL reset_err late=%0b ldata=%0h ovf=%0b exp 0", late_error, late_data, overflow_error);
      end
   endtask

   task automatic test_basic_fire;
      logic found = 1'b0;
      logic [63:0] at = 64'd0;
      set_counter(64'd100);
      write_entry(64'd110, 128'hA5);
      for (int i = 0; i < 60 && !found; i++) begin
         if (counter_matched) begin found = 1'b1; at = counter; end
         else @(negedge CLK100MHZ);
      end
      checks++;
      if (!found || at !== 64'd111) begin
         failures++; $display("FAIL basic_fire_time found=%0b counter=%0d exp=111", found, at);
      end
      checks++;
      if (gpo_data !== 128'hA5 || late_error !== 1'b0) begin
         failures++; $display("FAIL basic_fire_data gpo=%0h late=%0b exp a5/0", gpo_data, late_error);
      end
      @(negedge CLK100MHZ);
      checks++;
      if (counter_matched !== 1'b0 || gpo_data !== 128'hA5 || empty !== 1'b1) begin
         failures++; $display("FAIL basic_hold matched=%0b gpo=%0h empty=%0b exp 0/a5/1", counter_matched, gpo_data, empty);
      end
   endtask

   task automatic test_late;
      logic found = 1'b0;
      logic [63:0] at = 64'd0;
      set_counter(64'd500);
      write_entry(64'd200, 128'h1);
      for (int i = 0; i < 20 && !found; i++) begin
         if (counter_matched) begin found = 1'b1; at = counter; end
         else @(negedge CLK100MHZ);
      end
      checks++;
      if (!found || at !== 64'd504) begin
         failures++; $display("FAIL late_fire_time found=%0b counter=%0d exp=504", found, at);
      end
      checks++;
      if (late_error !== 1'b1 || late_data !== 128'h1 || gpo_data !== 128'h1) begin
         failures++; $display("FAIL late_flags late=%0b ldata=%0h gpo=%0h exp 1/1/1", late_error, late_data, gpo_data);
      end
      pulse_clear();
      checks++;
      if (late_error !== 1'b0 || late_data !== 128'h1) begin
         failures++; $display("FAIL late_clear late=%0b ldata=%0h exp 0/1", late_error, late_data);
      end
   endtask

   task automatic test_spacing;
      gpo_entry_t  vec [3];
      logic [63:0] exp_at [3];
      logic [63:0] at [3];
      logic [127:0] gd [3];
      logic        le [3];
      logic [127:0] ld [3];
      int n = 0;
      vec[0] = '{stamp: 64'd1000, payload: 128'h11};
      vec[1] = '{stamp: 64'd1001, payload: 128'h22};
      vec[2] = '{stamp: 64'd1010, payload: 128'h33};
      exp_at[0] = 64'd1001;
      exp_at[1] = 64'd1000 + 64'(MIN_SPACING) + 64'd1;
      exp_at[2] = 64'd1011;
      set_counter(64'd900);
      for (int k = 0; k < 3; k++) write_entry(vec[k].stamp, vec[k].payload);
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK100MHZ);
         if (counter_matched) begin
            if (n < 3) begin
               at[n] = counter; gd[n] = gpo_data; le[n] = late_error; ld[n] = late_data;
            end
            n++;
         end
      end
      checks++;
      if (n != 3) begin failures++; $display("FAIL spacing_count got=%0d exp=3", n); end
      for (int k = 0; k < 3 && k < n; k++) begin
         checks++;
         if (at[k] !== exp_at[k] || gd[k] !== vec[k].payload) begin
            failures++; $display("FAIL spacing_fire%0d counter=%0d gpo=%0h exp %0d/%0h", k, at[k], gd[k], exp_at[k], vec[k].payload);
         end
         checks++;
         if (le[k] !== (k != 0) || (k != 0 && ld[k] !== 128'h22)) begin
            failures++; $display("FAIL spacing_late%0d late=%0b ldata=%0h exp %0b/22", k, le[k], ld[k], (k != 0));
         end
      end
      pulse_clear();
   endtask

   task automatic test_overflow;
      int n = 0;
      set_counter(64'd0);
      for (int k = 0; k < 18; k++) write_entry(64'd1000 + 64'(10 * k), 128'(k + 1));
      checks++;
      if (full !== 1'b1 || fifo_count !== 5'd16 || overflow_error !== 1'b1) begin
         failures++; $display("FAIL overflow_state full=%0b count=%0d ovf=%0b exp 1/16/1", full, fifo_count, overflow_error);
      end
      set_counter(64'd990);
      for (int i = 0; i < 250; i++) begin
         @(negedge CLK100MHZ);
         if (counter_matched) n++;
      end
      checks++;
      if (n != 17) begin failures++; $display("FAIL overflow_fires got=%0d exp=17", n); end
      checks++;
      if (gpo_data !== 128'd17 || late_error !== 1'b0 || empty !== 1'b1) begin
         failures++; $display("FAIL overflow_drain gpo=%0h late=%0b empty=%0b exp 11/0/1", gpo_data, late_error, empty);
      end
      pulse_clear();
      checks++;
      if (overflow_error !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%0b exp=0", overflow_error); end
   endtask

   task automatic test_flush_armed;
      int n = 0;
      set_counter(64'd290);
      write_entry(64'd300, 128'hBEEF);
      for (int i = 0; i < 40 && counter != 64'd300; i++) @(negedge CLK100MHZ);
      checks++;
      if (counter !== 64'd300) begin failures++; $display("FAIL flush_wait counter=%0d exp=300", counter); end
      flush = 1'b1;
      wr_en = 1'b1; wr_time = 64'd310; wr_data = 128'hDEAD;
      @(negedge CLK100MHZ);
      flush = 1'b0;
      wr_en = 1'b0;
      checks++;
      if (counter_matched !== 1'b0 || empty !== 1'b1 || fifo_count !== 5'd0 || gpo_data !== 128'd17) begin
         failures++; $display("FAIL flush_state matched=%0b empty=%0b count=%0d gpo=%0h exp 0/1/0/11", counter_matched, empty, fifo_count, gpo_data);
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK100MHZ);
         if (counter_matched) n++;
      end
      checks++;
      if (n != 0) begin failures++; $display("FAIL flush_no_fire pulses=%0d exp=0", n); end
   endtask

   task automatic test_reset_mid_queue;
      int n = 0;
      set_counter(64'd0);
      for (int k = 0; k < 5; k++) write_entry(64'd100 + 64'(10 * k), 128'(k + 64));
      reset = 1'b1;
      @(negedge CLK100MHZ);
      reset = 1'b0;
      checks++;
      if (counter_matched !== 1'b0 || empty !== 1'b1 || fifo_count !== 5'd0 || full !== 1'b0) begin
         failures++; $display("FAIL rstq_fifo matched=%0b empty=%0b count=%0d full=%0b exp 0/1/0/0", counter_matched, empty, fifo_count, full);
      end
      checks++;
      if (gpo_data !== 128'd0 || late_data !== 128'd0 || late_error !== 1'b0 || overflow_error !== 1'b0) begin
         failures++; $display("FAIL rstq_out gpo=%0h ldata=%0h late=%0b ovf=%0b exp 0", gpo_data, late_data, late_error, overflow_error);
      end
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK100MHZ);
         if (counter_matched) n++;
      end
      checks++;
      if (n != 0 || empty !== 1'b1) begin
         failures++; $display("FAIL rstq_no_fire pulses=%0d empty=%0b exp 0/1", n, empty);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fire();
      test_late();
      test_spacing();
      test_overflow();
      test_flush_armed();
      test_reset_mid_queue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
